wb_arbiter: RTL and testbench
=============================

Name: wb_arbiter

Overview:
- Shares the single writeback bus (the wb_* inputs of the rename table, ROB and reservation stations) among NREQ execution units.
- Each cycle it grants at most one valid requester and registers the winner's packet onto the bus.
- Round-robin fairness; squashes all in-flight output on rob_flush.

Parameters:
- NREQ, 4, number of requesting functional units (2..8).
- ROBID_W, 8, ROB tag width.
- RD_W, 6, destination register field width; passed through unmodified.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  NREQ  unit i has a result packet
- req_ready  out  NREQ  unit i's packet is accepted this cycle (one-hot or zero)
- req_error  in  NREQ  per-unit exception flag
- req_robid  in  NREQ*ROBID_W  per-unit ROB tag, unit i at [i*ROBID_W +: ROBID_W]
- req_rd  in  NREQ*RD_W  per-unit destination field
- req_result  in  NREQ*32  per-unit result
- rob_flush  in  1  pipeline flush from ROB
- rob_head  in  ROBID_W  oldest ROB tag; used only with WB_ARB_AGE_EN, otherwise ignored
- wb_valid  out  1  bus valid
- wb_error  out  1  bus exception flag
- wb_robid  out  ROBID_W  bus ROB tag
- wb_rd  out  RD_W  bus destination field
- wb_result  out  32  bus result

Behaviour:
- Reset (rst=1 at posedge): valid_q=0, rr_ptr=0, error/robid/rd/result regs=0. During reset cycles req_ready=0.
- Grant is combinational:
  - Search req_valid starting at index rr_ptr, ascending, wrapping NREQ-1 -> 0.
  - The first valid index g gets req_ready[g]=1; all other bits are 0.
  - No valid requester: req_ready=0.
- Handshake:
  - A requester holds valid, error, robid, rd and result stable until it sees ready.
  - req_valid must not depend combinationally on req_ready.
  - Transfer happens when req_valid[i] & req_ready[i] at posedge.
- Latency: accepted packet appears on wb_* exactly 1 cycle later.
- Throughput: 1 packet/cycle; the bus has no backpressure.
- At posedge with a grant:
  - valid_q<=1 and the packet regs load from unit g.
  - rr_ptr <= (g+1) mod NREQ.
- At posedge without a grant: valid_q<=0; packet regs hold their value (don't-care); rr_ptr unchanged.
- Outputs:
  - wb_valid = valid_q & ~rob_flush.
  - The other wb_* outputs come directly from the registers.
- rob_flush=1:
  - req_ready forced to 0 and nothing accepted.
  - valid_q<=0 at that posedge.
  - rr_ptr unchanged.
  - Units discard their own pending packets.
- Fairness: with all NREQ units continuously valid, each unit is granted exactly once every NREQ cycles.
- Single requester continuously valid: granted every cycle.
- rst and rob_flush together: rst wins (same end state).
- wb_rd and wb_error pass through unmodified. The arbiter does not interpret rd (including rd==0).

Optional Feature:
- WB_ARB_AGE_EN defined:
  - Among valid requesters, grant the one with the smallest age = (req_robid - rob_head) mod 2^ROBID_W.
  - Ties go to the lowest index.
  - rr_ptr is not used, and not updated.
  - Purpose: oldest-first writeback, which shortens retire stalls.
- Undefined: round-robin as above; rob_head is ignored.
- All other behaviour is identical in both builds (latency, flush, reset).

Decomposition:
- Package wb_arb_pkg holds:
  - WB_ROBID_W=8, WB_RD_W=6, WB_DATA_W=32.
  - A wb_pkt_t struct {error, robid, rd, result}.
  - A function for modular ROB age.
- One sub-module, wb_pick, is natural:
  - Inputs: valid vector, rr_ptr (or ages under WB_ARB_AGE_EN).
  - Outputs: one-hot grant and encoded index.
  - Purely combinational.
- wb_arbiter owns the pointer, the output register and the flush gating.

Test Plan:
- Reset, then req_valid=0 for 5 cycles -> req_ready=0 and wb_valid=0 throughout.
- Unit 2 only, robid=0x15, rd=6'h0A, result=0xDEADBEEF -> req_ready[2]=1 on cycle t; cycle t+1: wb_valid=1, wb_robid=0x15, wb_rd=0x0A, wb_result=0xDEADBEEF.
- All 4 units continuously valid for 8 cycles from reset -> grant order 0,1,2,3,0,1,2,3; wb_valid=1 every cycle from the 2nd.
- Unit 1 granted at t; rob_flush=1 at t+1 with units 0,3 valid:
  - t+1: wb_valid=0 and req_ready=0.
  - t+2: wb_valid=0.
  - t+2 grant is unit 3 (rr_ptr=2 kept).
- Units 0 and 3 valid, unit 3 req_error=1 -> unit 3's packet appears with wb_error=1; unit 0 keeps holding until its grant.
- WB_ARB_AGE_EN: rob_head=0xFE, unit0 robid=0x05, unit1 robid=0xFF -> unit 1 granted first (age 1 vs 7), unit 0 next cycle.

Source files
------------

// File: rtl/wb_arb_pkg.sv
// Shared widths, packet type and ROB-age helper for the writeback arbiter.
// Optional feature macro: WB_ARB_AGE_EN (oldest-first arbitration).
package wb_arb_pkg;
   localparam int WB_ROBID_W = 8;
   localparam int WB_RD_W    = 6;
   localparam int WB_DATA_W  = 32;

   typedef struct packed {
      logic                  error;
      logic [WB_ROBID_W-1:0] robid;
      logic [WB_RD_W-1:0]    rd;
      logic [WB_DATA_W-1:0]  result;
   } wb_pkt_t;

   // Distance of a tag from the ROB head; wraps naturally at 2^WB_ROBID_W.
   function automatic logic [WB_ROBID_W-1:0] rob_age(
      input logic [WB_ROBID_W-1:0] tag,
      input logic [WB_ROBID_W-1:0] head
   );
      return tag - head;
   endfunction
endpackage

// File: rtl/wb_pick.sv
// Combinational winner selection: round-robin from rr_ptr, or smallest age
// (ties to lowest index) when WB_ARB_AGE_EN is defined.
module wb_pick #(
   parameter int NREQ  = 4,
   parameter int IDX_W = 2
`ifdef WB_ARB_AGE_EN
   ,
   parameter int AGE_W = 8
`endif
) (
   input  logic [NREQ-1:0]       valid,
`ifdef WB_ARB_AGE_EN
   input  logic [NREQ*AGE_W-1:0] ages,
`else
   input  logic [IDX_W-1:0]      rr_ptr,
`endif
   output logic [NREQ-1:0]       grant,
   output logic [IDX_W-1:0]      grant_idx,
   output logic                  any
);

`ifdef WB_ARB_AGE_EN
   always_comb begin : age_search
      logic [AGE_W-1:0] best;
      best      = '0;
      grant     = '0;
      grant_idx = '0;
      any       = 1'b0;
      // Strict less-than keeps the lowest index on ties.
      for (int i = 0; i < NREQ; i++) begin
         if (valid[i] && (!any || ages[i*AGE_W +: AGE_W] < best)) begin
            any       = 1'b1;
            best      = ages[i*AGE_W +: AGE_W];
            grant_idx = IDX_W'(i);
         end
      end
      grant[grant_idx] = any;
   end
`else
   always_comb begin : rr_search
      int j;
      j         = 0;
      grant     = '0;
      grant_idx = '0;
      any       = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
         j = int'(rr_ptr) + k;
         if (j >= NREQ) j = j - NREQ;
         if (!any && valid[j]) begin
            any       = 1'b1;
            grant_idx = IDX_W'(j);
         end
      end
      grant[grant_idx] = any;
   end
`endif

endmodule

// File: rtl/wb_arbiter.sv
// Writeback bus arbiter: grants one of NREQ units per cycle and registers its
// packet onto the bus; WB_ARB_AGE_EN switches to oldest-first selection.
module wb_arbiter
   import wb_arb_pkg::*;
#(
   parameter int NREQ    = 4,
   parameter int ROBID_W = WB_ROBID_W,
   parameter int RD_W    = WB_RD_W
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NREQ-1:0]         req_valid,
   output logic [NREQ-1:0]         req_ready,
   input  logic [NREQ-1:0]         req_error,
   input  logic [NREQ*ROBID_W-1:0] req_robid,
   input  logic [NREQ*RD_W-1:0]    req_rd,
   input  logic [NREQ*32-1:0]      req_result,
   input  logic                    rob_flush,
   input  logic [ROBID_W-1:0]      rob_head,
   output logic                    wb_valid,
   output logic                    wb_error,
   output logic [ROBID_W-1:0]      wb_robid,
   output logic [RD_W-1:0]         wb_rd,
   output logic [31:0]             wb_result
);

   localparam int IDX_W = $clog2(NREQ);

   logic [NREQ-1:0]    pick_grant;
   logic [IDX_W-1:0]   pick_idx;
   logic               pick_any;
   logic               take;
   logic [IDX_W-1:0]   rr_ptr_reg;
   logic               valid_reg;
   logic               error_reg;
   logic [ROBID_W-1:0] robid_reg;
   logic [RD_W-1:0]    rd_reg;
   logic [31:0]        result_reg;

`ifdef WB_ARB_AGE_EN
   logic [NREQ*ROBID_W-1:0] ages;

   genvar gi;
   generate
      for (gi = 0; gi < NREQ; gi++) begin : g_age
         assign ages[gi*ROBID_W +: ROBID_W] = rob_age(req_robid[gi*ROBID_W +: ROBID_W], rob_head);
      end
   endgenerate

   wb_pick #(
      .NREQ  (NREQ),
      .IDX_W (IDX_W),
      .AGE_W (ROBID_W)
   ) u_pick (
      .valid     (req_valid),
      .ages      (ages),
      .grant     (pick_grant),
      .grant_idx (pick_idx),
      .any       (pick_any)
   );
`else
   logic unused_rob_head;
   assign unused_rob_head = ^rob_head;

   wb_pick #(
      .NREQ  (NREQ),
      .IDX_W (IDX_W)
   ) u_pick (
      .valid     (req_valid),
      .rr_ptr    (rr_ptr_reg),
      .grant     (pick_grant),
      .grant_idx (pick_idx),
      .any       (pick_any)
   );
`endif

   // A flush (or reset) blocks acceptance so squashed units are never consumed.
   assign req_ready = (rst || rob_flush) ? '0 : pick_grant;
   assign take      = pick_any && !rst && !rob_flush;

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_reg  <= 1'b0;
         rr_ptr_reg <= '0;
         error_reg  <= 1'b0;
         robid_reg  <= '0;
         rd_reg     <= '0;
         result_reg <= '0;
      end else begin
         valid_reg <= take;
         if (take) begin
            error_reg  <= req_error[pick_idx];
            robid_reg  <= req_robid[pick_idx*ROBID_W +: ROBID_W];
            rd_reg     <= req_rd[pick_idx*RD_W +: RD_W];
            result_reg <= req_result[pick_idx*32 +: 32];
`ifndef WB_ARB_AGE_EN
            rr_ptr_reg <= (pick_idx == IDX_W'(NREQ-1)) ? '0 : pick_idx + 1'b1;
`endif
         end
      end
   end

   assign wb_valid  = valid_reg & ~rob_flush;
   assign wb_error  = error_reg;
   assign wb_robid  = robid_reg;
   assign wb_rd     = rd_reg;
   assign wb_result = result_reg;

endmodule

// File: tb/tb_wb_arbiter.sv
// Scoreboard bench for wb_arbiter: a reference grant model pushes accepted
// packets, which are popped and compared against the bus one cycle later.
module tb_wb_arbiter;
   localparam int N = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [N-1:0]  req_valid = '0;
   logic [N-1:0]  req_ready;
   logic [N-1:0]  req_error = '0;
   logic [N*8-1:0]  req_robid;
   logic [N*6-1:0]  req_rd;
   logic [N*32-1:0] req_result;
   logic          rob_flush = 1'b0;
   logic [7:0]    rob_head = '0;
   logic          wb_valid, wb_error;
   logic [7:0]    wb_robid;
   logic [5:0]    wb_rd;
   logic [31:0]   wb_result;

   logic [7:0]  robid [N];
   logic [5:0]  rd    [N];
   logic [31:0] res   [N];

   typedef struct {
      logic        error;
      logic [7:0]  robid;
      logic [5:0]  rd;
      logic [31:0] result;
   } pkt_t;

   pkt_t sb[$];
   int   total = 0;
   int   bad = 0;
   int   model_ptr = 0;
   bit   pending = 0;
   int   last_grant = -1;

   always #5 clk = ~clk;

   always_comb begin
      req_robid  = '0;
      req_rd     = '0;
      req_result = '0;
      for (int i = 0; i < N; i++) begin
         req_robid[i*8 +: 8]    = robid[i];
         req_rd[i*6 +: 6]       = rd[i];
         req_result[i*32 +: 32] = res[i];
      end
   end

   wb_arbiter #(.NREQ(N), .ROBID_W(8), .RD_W(6)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_error  (req_error),
      .req_robid  (req_robid),
      .req_rd     (req_rd),
      .req_result (req_result),
      .rob_flush  (rob_flush),
      .rob_head   (rob_head),
      .wb_valid   (wb_valid),
      .wb_error   (wb_error),
      .wb_robid   (wb_robid),
      .wb_rd      (wb_rd),
      .wb_result  (wb_result)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic int model_pick();
      int g;
      g = -1;
`ifdef WB_ARB_AGE_EN
      begin
         logic [7:0] best, age;
         best = '0;
         for (int i = 0; i < N; i++) begin
            age = robid[i] - rob_head;
            if (req_valid[i] && (g < 0 || age < best)) begin
               g    = i;
               best = age;
            end
         end
      end
`else
      for (int k = 0; k < N; k++) begin
         if (g < 0 && req_valid[(model_ptr + k) % N]) g = (model_ptr + k) % N;
      end
`endif
      return g;
   endfunction

   task automatic randomize_unit(input int i);
      robid[i]     = 8'($urandom);
      rd[i]        = 6'($urandom);
      res[i]       = $urandom;
      req_error[i] = 1'($urandom_range(0, 1));
   endtask

   // One clock: check grant and bus at the negedge, then advance past posedge.
   task automatic step();
      int         g;
      logic [3:0] one;
      logic [3:0] exp_ready;
      pkt_t       p;
      @(negedge clk);
      g   = (rst || rob_flush) ? -1 : model_pick();
      one = 4'b0001;
      exp_ready = (g >= 0) ? (one << g) : 4'b0000;
      check("ready", req_ready, exp_ready);
      if (pending) begin
         p = sb.pop_front();
         if (rob_flush) begin
            check("flush_valid", wb_valid, 1'b0);
         end else begin
            check("wb_valid", wb_valid, 1'b1);
            check("wb_error", wb_error, p.error);
            check("wb_robid", wb_robid, p.robid);
            check("wb_rd", wb_rd, p.rd);
            check("wb_result", wb_result, p.result);
         end
      end else begin
         check("idle_valid", wb_valid, 1'b0);
      end
      $display("cycle: rst=%0b flush=%0b valid=%b ready=%b grant=%0d wb_valid=%0b wb_robid=%0h",
               rst, rob_flush, req_valid, req_ready, g, wb_valid, wb_robid);
      pending    = 0;
      last_grant = g;
      if (rst) begin
         model_ptr = 0;
      end else if (g >= 0) begin
         sb.push_back('{req_error[g], robid[g], rd[g], res[g]});
         pending = 1;
`ifndef WB_ARB_AGE_EN
         model_ptr = (g + 1) % N;
`endif
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      for (int i = 0; i < N; i++) begin
         robid[i] = '0;
         rd[i]    = '0;
         res[i]   = '0;
      end
      @(posedge clk);
      #1;
      step();
      rst = 1'b0;

      repeat (5) step();

      robid[2] = 8'h15; rd[2] = 6'h0A; res[2] = 32'hDEADBEEF; req_error[2] = 1'b0;
      req_valid = 4'b0100;
      step();
      check("unit2_grant", last_grant, 2);
      req_valid = 4'b0000;
      step();

      rst = 1'b1;
      step();
      rst = 1'b0;
      req_valid = 4'b1111;
      for (int c = 0; c < 8; c++) begin
         step();
`ifndef WB_ARB_AGE_EN
         check("rr_order", last_grant, c % N);
`endif
         if (last_grant >= 0) randomize_unit(last_grant);
      end

      req_valid = 4'b0010;
      step();
      check("pre_flush_grant", last_grant, 1);
      req_valid = 4'b1001;
      req_error[3] = 1'b1;
      req_error[0] = 1'b0;
      rob_flush = 1'b1;
      step();
      rob_flush = 1'b0;
      step();
`ifndef WB_ARB_AGE_EN
      check("post_flush_grant", last_grant, 3);
`endif
      if (last_grant >= 0) req_valid[last_grant] = 1'b0;
      step();
      if (last_grant >= 0) req_valid[last_grant] = 1'b0;
      step();

`ifdef WB_ARB_AGE_EN
      rob_head = 8'hFE;
      robid[0] = 8'h05;
      robid[1] = 8'hFF;
      req_valid = 4'b0011;
      step();
      check("age_first", last_grant, 1);
      req_valid = 4'b0001;
      step();
      check("age_second", last_grant, 0);
      req_valid = 4'b0000;
      step();
`endif

      for (int c = 0; c < 60; c++) begin
         for (int i = 0; i < N; i++) begin
            if (!req_valid[i] && $urandom_range(0, 1) == 1) begin
               req_valid[i] = 1'b1;
               randomize_unit(i);
            end
         end
         rob_head  = 8'($urandom);
         rob_flush = ($urandom_range(0, 9) == 0);
         step();
         if (rob_flush) req_valid = '0;
         else if (last_grant >= 0) req_valid[last_grant] = 1'b0;
         rob_flush = 1'b0;
      end
      req_valid = '0;
      step();
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
